// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Write-side initiator for the register file. Merges the ALU
//               result stream (one per cycle, no backpressure) and the load
//               result stream (valid/ready) onto one registered write port.
//               Loads that arrive while the ALU owns the port wait in a small
//               FIFO. Exports a per-register busy mask of pending load
//               destinations and a sticky hazard flag.
// Ports       : clk, rst          - clock, async active-high reset
//               alu_valid_i/rd/data - ALU result stream
//               mem_valid_i/ready_o/rd/data - load result stream
//               rd_o/datawb_o/regwren_o - registered register-file write port
//               busy_o            - bit r: load write to xr queued or in output
//               err_o             - sticky: ALU wrote a busy register
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid_i,
    input  logic [4:0]        alu_rd_i,
    input  logic [DWIDTH-1:0] alu_data_i,
    input  logic              mem_valid_i,
    output logic              mem_ready_o,
    input  logic [4:0]        mem_rd_i,
    input  logic [DWIDTH-1:0] mem_data_i,
    output logic [4:0]        rd_o,
    output logic [DWIDTH-1:0] datawb_o,
    output logic              regwren_o,
    output logic [31:0]       busy_o,
    output logic              err_o
);

    localparam int            AW     = $clog2(DEPTH);
    localparam int            CW     = AW + 1;
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

    // FIFO storage (data only, no reset needed: validity lives in count/pointers)
    logic [4:0]        fifo_rd_q   [DEPTH];
    logic [DWIDTH-1:0] fifo_data_q [DEPTH];

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q,  count_d;

    logic [4:0]        rd_q,        rd_d;
    logic [DWIDTH-1:0] data_q,      data_d;
    logic              wren_q,      wren_d;
    logic              from_load_q, from_load_d;
    logic              err_q,       err_d;

    logic              w_alu_wr;
    logic              w_accept_nz;
    logic              w_fifo_empty;
    logic              w_push;
    logic              w_pop;
    logic [31:0]       w_busy;

    // Ready depends on registered count only, so a same-edge pop never
    // feeds combinationally back into ready.
    assign mem_ready_o  = !rst && (count_q != C_FULL);
    assign w_alu_wr     = alu_valid_i && (alu_rd_i != 5'd0);
    // Accepted loads to x0 are consumed here and never reach the port or FIFO.
    assign w_accept_nz  = mem_valid_i && mem_ready_o && (mem_rd_i != 5'd0);
    assign w_fifo_empty = (count_q == '0);

    // Output-port selection: ALU > FIFO head > bypass of a fresh load.
    always_comb begin
        rd_d        = rd_q;
        data_d      = data_q;
        wren_d      = 1'b0;
        from_load_d = 1'b0;
        w_pop       = 1'b0;
        if (w_alu_wr) begin
            rd_d   = alu_rd_i;
            data_d = alu_data_i;
            wren_d = 1'b1;
        end else if (!w_fifo_empty) begin
            rd_d        = fifo_rd_q[rd_ptr_q];
            data_d      = fifo_data_q[rd_ptr_q];
            wren_d      = 1'b1;
            from_load_d = 1'b1;
            w_pop       = 1'b1;
        end else if (w_accept_nz) begin
            rd_d        = mem_rd_i;
            data_d      = mem_data_i;
            wren_d      = 1'b1;
            from_load_d = 1'b1;
        end
    end

    // A fresh load is stored only when it could not bypass straight out.
    assign w_push = w_accept_nz && (w_alu_wr || !w_fifo_empty);

    always_comb begin
        wr_ptr_d = w_push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = w_pop  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        count_d  = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Busy mask: every occupied FIFO slot plus a load currently on the port.
    // A slot is occupied when its distance from the read pointer is < count.
    always_comb begin
        w_busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ({1'b0, AW'(i) - rd_ptr_q} < count_q) begin
                w_busy[fifo_rd_q[i]] = 1'b1;
            end
        end
        if (wren_q && from_load_q) begin
            w_busy[rd_q] = 1'b1;
        end
        w_busy[0] = 1'b0;
    end

    assign err_d = err_q | (w_alu_wr && w_busy[alu_rd_i]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_q        <= '0;
            data_q      <= '0;
            wren_q      <= 1'b0;
            from_load_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_q        <= rd_d;
            data_q      <= data_d;
            wren_q      <= wren_d;
            from_load_q <= from_load_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_rd_q[wr_ptr_q]   <= mem_rd_i;
            fifo_data_q[wr_ptr_q] <= mem_data_i;
        end
    end

    assign rd_o      = rd_q;
    assign datawb_o  = data_q;
    assign regwren_o = wren_q;
    assign busy_o    = w_busy;
    assign err_o     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Self-checking bench for regfile_wb_arbiter. A queue-based
//               model tracks pending loads and the write port; a negedge
//               process compares every output each cycle, and directed
//               literal checks pin the model to hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          alu_valid_i;
    logic [4:0]    alu_rd_i;
    logic [DW-1:0] alu_data_i;
    logic          mem_valid_i;
    logic          mem_ready_o;
    logic [4:0]    mem_rd_i;
    logic [DW-1:0] mem_data_i;
    logic [4:0]    rd_o;
    logic [DW-1:0] datawb_o;
    logic          regwren_o;
    logic [31:0]   busy_o;
    logic          err_o;

    regfile_wb_arbiter #(.DWIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid_i (alu_valid_i),
        .alu_rd_i    (alu_rd_i),
        .alu_data_i  (alu_data_i),
        .mem_valid_i (mem_valid_i),
        .mem_ready_o (mem_ready_o),
        .mem_rd_i    (mem_rd_i),
        .mem_data_i  (mem_data_i),
        .rd_o        (rd_o),
        .datawb_o    (datawb_o),
        .regwren_o   (regwren_o),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h @%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [4+DW-1:0] mq[$];          // pending loads {rd, data}, oldest first
    logic            m_wren      = 1'b0;
    logic            m_from_load = 1'b0;
    logic            m_err       = 1'b0;
    logic [4:0]      m_rd        = '0;
    logic [DW-1:0]   m_data      = '0;

    function automatic logic [31:0] m_busy();
        logic [31:0] b;
        b = '0;
        foreach (mq[k]) b[mq[k][4+DW-1:DW]] = 1'b1;
        if (m_wren && m_from_load) b[m_rd] = 1'b1;
        b[0] = 1'b0;
        return b;
    endfunction

    always @(posedge clk or posedge rst) begin
        logic          acc;
        logic [31:0]   b;
        logic [4+DW-1:0] h;
        if (rst) begin
            mq.delete();
            m_wren = 1'b0; m_from_load = 1'b0; m_err = 1'b0;
            m_rd = '0; m_data = '0;
        end else begin
            b   = m_busy();
            acc = mem_valid_i && (mq.size() < DEPTH) && (mem_rd_i != 5'd0);
            if (alu_valid_i && alu_rd_i != 5'd0) begin
                if (b[alu_rd_i]) m_err = 1'b1;
                m_wren = 1'b1; m_from_load = 1'b0;
                m_rd = alu_rd_i; m_data = alu_data_i;
                if (acc) mq.push_back({mem_rd_i, mem_data_i});
            end else if (mq.size() > 0) begin
                h = mq.pop_front();
                m_wren = 1'b1; m_from_load = 1'b1;
                m_rd = h[4+DW-1:DW]; m_data = h[DW-1:0];
                if (acc) mq.push_back({mem_rd_i, mem_data_i});
            end else if (acc) begin
                m_wren = 1'b1; m_from_load = 1'b1;
                m_rd = mem_rd_i; m_data = mem_data_i;
            end else begin
                m_wren = 1'b0; m_from_load = 1'b0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!rst) begin
            chk("regwren",   64'(regwren_o),   64'(m_wren));
            chk("rd",        64'(rd_o),        64'(m_rd));
            chk("datawb",    64'(datawb_o),    64'(m_data));
            chk("busy",      64'(busy_o),      64'(m_busy()));
            chk("err",       64'(err_o),       64'(m_err));
            chk("mem_ready", 64'(mem_ready_o), 64'(mq.size() < DEPTH));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic av, input logic [4:0] ard, input logic [DW-1:0] ad,
                         input logic mv, input logic [4:0] mrd, input logic [DW-1:0] md);
        alu_valid_i = av; alu_rd_i = ard; alu_data_i = ad;
        mem_valid_i = mv; mem_rd_i = mrd; mem_data_i = md;
    endtask

    // One cycle: drive just after negedge, return just after the posedge.
    task automatic cyc(input logic av, input logic [4:0] ard, input logic [DW-1:0] ad,
                       input logic mv, input logic [4:0] mrd, input logic [DW-1:0] md);
        @(negedge clk); #1;
        drive(av, ard, ad, mv, mrd, md);
        @(posedge clk); #1;
    endtask

    task automatic idle();
        cyc(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    endtask

    initial begin
        drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("reset_regwren", 64'(regwren_o),   64'd0);
        chk("reset_ready",   64'(mem_ready_o), 64'd0);
        chk("reset_busy",    64'(busy_o),      64'd0);
        chk("reset_err",     64'(err_o),       64'd0);
        chk("reset_rd",      64'(rd_o),        64'd0);
        @(negedge clk); #1 rst = 1'b0;

        // ALU only
        cyc(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, '0);
        chk("alu_wren", 64'(regwren_o), 64'd1);
        chk("alu_rd",   64'(rd_o),      64'd5);
        chk("alu_data", 64'(datawb_o),  64'hDEADBEEF);
        cyc(1'b1, 5'd0, 32'h11111111, 1'b0, 5'd0, '0);
        chk("alu_x0_wren", 64'(regwren_o), 64'd0);
        chk("alu_x0_hold", 64'(rd_o),      64'd5);

        // Bypass
        cyc(1'b0, 5'd0, '0, 1'b1, 5'd7, 32'h1234);
        chk("byp_wren", 64'(regwren_o), 64'd1);
        chk("byp_rd",   64'(rd_o),      64'd7);
        chk("byp_data", 64'(datawb_o),  64'h1234);
        chk("byp_busy", 64'(busy_o),    64'h80);
        idle();
        chk("byp_busy_clr", 64'(busy_o),    64'd0);
        chk("byp_wren_clr", 64'(regwren_o), 64'd0);

        // Load to x0 is discarded
        cyc(1'b0, 5'd0, '0, 1'b1, 5'd0, 32'h5555);
        chk("load_x0_wren", 64'(regwren_o), 64'd0);

        // Contention
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 5'(10 + i), 32'hA0 + 32'(i), i < 4, 5'(i + 1), 32'h100 + 32'(i));
            if (i == 3) begin
                chk("cont_busy",  64'(busy_o),      64'h1E);
                chk("cont_ready", 64'(mem_ready_o), 64'd0);
            end
        end
        for (int i = 0; i < 4; i++) begin
            idle();
            chk("cont_rd",   64'(rd_o),     64'(i + 1));
            chk("cont_data", 64'(datawb_o), 64'h100 + 64'(i));
        end
        chk("cont_busy_last", 64'(busy_o), 64'h10);
        idle();
        chk("cont_busy_done", 64'(busy_o), 64'd0);

        // Full FIFO with simultaneous push/pop
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 5'd20, 32'hB0, 1'b1, 5'(i + 1), 32'h200 + 32'(i));
        @(negedge clk); #1;
        drive(1'b0, 5'd0, '0, 1'b1, 5'd8, 32'h208);
        chk("full_ready0", 64'(mem_ready_o), 64'd0);
        @(posedge clk); #1;
        chk("full_pop1", 64'(rd_o), 64'd1);
        @(negedge clk); #1;
        chk("full_ready1", 64'(mem_ready_o), 64'd1);
        @(posedge clk); #1;
        chk("full_pop2", 64'(rd_o), 64'd2);
        idle(); chk("full_pop3", 64'(rd_o), 64'd3);
        idle(); chk("full_pop4", 64'(rd_o), 64'd4);
        idle(); chk("full_pop8", 64'(rd_o), 64'd8);
        chk("full_data8", 64'(datawb_o), 64'h208);
        idle();

        // Hazard
        cyc(1'b1, 5'd20, 32'hC0, 1'b1, 5'd9, 32'h999);
        chk("haz_busy9", 64'(busy_o[9]), 64'd1);
        cyc(1'b1, 5'd9, 32'h55, 1'b0, 5'd0, '0);
        chk("haz_err", 64'(err_o), 64'd1);
        repeat (3) idle();
        chk("haz_err_sticky", 64'(err_o), 64'd1);

        // Async reset with 3 queued loads
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 5'd21, 32'hD0, 1'b1, 5'(i + 1), 32'h300 + 32'(i));
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        chk("arst_wren", 64'(regwren_o), 64'd0);
        chk("arst_busy", 64'(busy_o),    64'd0);
        chk("arst_err",  64'(err_o),     64'd0);
        drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("arst_nowrite", 64'(regwren_o), 64'd0);
        end
        repeat (2) idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
